// File: rtl/rmii_tx.sv
// RMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS, IFG.
// Bytes go out as four LSB-first dibits on the 50 MHz reference clock.
module rmii_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD    = 60,
  parameter int APPEND_FCS     = 1,
  parameter int IFG_BYTES      = 12
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [1:0] txd,
  output logic       tx_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] SFD  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] PAD  = 3'd4;
  localparam logic [2:0] FCS  = 3'd5;
  localparam logic [2:0] IFG  = 3'd6;

  localparam int IFG_CLKS =
    (IFG_BYTES > 0) ? IFG_BYTES * 4 : 1;
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic [2:0]  state, st_n;
  logic [1:0]  sym, sym_n;
  logic [7:0]  sh, sh_n;
  logic [15:0] cnt, cnt_n;
  logic [10:0] byte_cnt, bc_n;
  logic [31:0] crc, crc_n;
  logic        last, last_n;
  logic        abort, abort_n;
  logic [1:0]  txd_n;
  logic        en_n, ready_n, busy_n;
  logic        done_n, urun_n;
  logic        ld, quiet, fin;
  logic [7:0]  ld_byte;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [10:0] sat_inc(
    input logic [10:0] v
  );
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  always_comb begin
    st_n    = state;
    cnt_n   = cnt;
    bc_n    = byte_cnt;
    crc_n   = crc;
    last_n  = last;
    abort_n = abort;
    urun_n  = 1'b0;
    ld      = 1'b0;
    ld_byte = 8'h00;
    quiet   = 1'b0;
    fin     = 1'b0;
    txd_n   = sh[1:0];
    sh_n    = {2'b00, sh[7:2]};
    sym_n   = sym + 2'd1;
    en_n    = 1'b1;
    unique case (state)
      IDLE: begin
        quiet = 1'b1;
        if (s_valid) begin
          quiet   = 1'b0;
          ld      = 1'b1;
          crc_n   = '1;
          bc_n    = '0;
          last_n  = 1'b0;
          abort_n = 1'b0;
          cnt_n   = 16'd1;
          if (PREAMBLE_BYTES == 0) begin
            st_n    = SFD;
            ld_byte = 8'hD5;
          end else begin
            st_n    = PRE;
            ld_byte = 8'h55;
          end
        end
      end
      PRE: if (sym == 2'd3) begin
        ld = 1'b1;
        if (int'(cnt) >= PREAMBLE_BYTES) begin
          st_n    = SFD;
          ld_byte = 8'hD5;
        end else begin
          cnt_n   = cnt + 16'd1;
          ld_byte = 8'h55;
        end
      end
      SFD, DATA: if (sym == 2'd3) begin
        if (state == SFD || !last) begin
          if (s_valid) begin
            st_n    = DATA;
            ld      = 1'b1;
            ld_byte = s_data;
            crc_n   = crc8(crc, s_data);
            bc_n    = sat_inc(byte_cnt);
            last_n  = s_last;
          end else begin
            // starved mid-frame: cut the frame, no FCS
            st_n    = IFG;
            cnt_n   = '0;
            quiet   = 1'b1;
            urun_n  = 1'b1;
            abort_n = 1'b1;
          end
        end else begin
          fin = 1'b1;
        end
      end
      PAD: if (sym == 2'd3) fin = 1'b1;
      FCS: if (sym == 2'd3) begin
        if (cnt >= 16'd4) begin
          st_n  = IFG;
          cnt_n = '0;
          quiet = 1'b1;
        end else begin
          ld      = 1'b1;
          ld_byte = crc[7:0];
          crc_n   = {8'h00, crc[31:8]};
          cnt_n   = cnt + 16'd1;
        end
      end
      IFG: begin
        quiet = 1'b1;
        if (int'(cnt) >= IFG_CLKS - 1)
          st_n = IDLE;
        else
          cnt_n = cnt + 16'd1;
      end
      default: begin
        st_n  = IDLE;
        quiet = 1'b1;
      end
    endcase

    if (fin) begin
      if (int'(byte_cnt) < MIN_PAYLOAD) begin
        st_n    = PAD;
        ld      = 1'b1;
        ld_byte = 8'h00;
        crc_n   = crc8(crc, 8'h00);
        bc_n    = sat_inc(byte_cnt);
      end else if (APPEND_FCS != 0) begin
        // crc holds the inverted FCS, shifted out low byte first
        st_n    = FCS;
        ld      = 1'b1;
        ld_byte = ~crc[7:0];
        crc_n   = {8'h00, ~crc[31:8]};
        cnt_n   = 16'd1;
      end else begin
        st_n  = IFG;
        cnt_n = '0;
        quiet = 1'b1;
      end
    end

    if (ld) begin
      txd_n = ld_byte[1:0];
      sh_n  = {2'b00, ld_byte[7:2]};
      sym_n = 2'd0;
    end
    if (quiet) begin
      txd_n = 2'b00;
      sh_n  = 8'h00;
      sym_n = 2'd0;
      en_n  = 1'b0;
    end

    done_n = (st_n == IFG) && !abort_n &&
             (int'(cnt_n) >= IFG_CLKS - 1);
    ready_n = (sym_n == 2'd3) &&
              ((st_n == SFD) ||
               (st_n == DATA && !last_n));
    busy_n = (st_n != IDLE);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sym         <= '0;
      sh          <= '0;
      cnt         <= '0;
      byte_cnt    <= '0;
      crc         <= '0;
      last        <= 1'b0;
      abort       <= 1'b0;
      txd         <= '0;
      tx_en       <= 1'b0;
      s_ready     <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= st_n;
      sym         <= sym_n;
      sh          <= sh_n;
      cnt         <= cnt_n;
      byte_cnt    <= bc_n;
      crc         <= crc_n;
      last        <= last_n;
      abort       <= abort_n;
      txd         <= txd_n;
      tx_en       <= en_n;
      s_ready     <= ready_n;
      tx_busy     <= busy_n;
      tx_done     <= done_n;
      tx_underrun <= urun_n;
    end
  end

endmodule

// File: tb/tb_rmii_tx.sv
// Bench for rmii_tx: three parameter variants, wire bytes
// checked against a scoreboard queue fed by the stimulus.
module tb_rmii_tx;

  logic       clk50;
  logic       rst_n;
  logic [7:0] s_data [3];
  logic       s_valid [3];
  logic       s_last [3];
  logic       rdy [3];
  logic [1:0] txd [3];
  logic       tx_en [3];
  logic       tx_busy [3];
  logic       tx_done [3];
  logic       tx_underrun [3];

  rmii_tx #(.MIN_PAYLOAD(60), .APPEND_FCS(1)) u0 (
    .clk50(clk50), .rst_n(rst_n),
    .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .s_ready(rdy[0]),
    .txd(txd[0]), .tx_en(tx_en[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
    .tx_underrun(tx_underrun[0])
  );

  rmii_tx #(.MIN_PAYLOAD(0), .APPEND_FCS(1)) u1 (
    .clk50(clk50), .rst_n(rst_n),
    .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .s_ready(rdy[1]),
    .txd(txd[1]), .tx_en(tx_en[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
    .tx_underrun(tx_underrun[1])
  );

  rmii_tx #(.MIN_PAYLOAD(60), .APPEND_FCS(0)) u2 (
    .clk50(clk50), .rst_n(rst_n),
    .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_last(s_last[2]), .s_ready(rdy[2]),
    .txd(txd[2]), .tx_en(tx_en[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2]),
    .tx_underrun(tx_underrun[2])
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exq [$];
  logic [7:0] pay [256];

  int cyc = 0;
  int en_len, fall_cyc, rise_cyc, idle_cyc;
  int done_cnt, done_cyc, urun_cnt, urun_cyc;
  int hs_cnt;
  logic [31:0] last4;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic int minp(input int d);
    return (d == 1) ? 0 : 60;
  endfunction

  function automatic bit fcsp(input int d);
    return d != 2;
  endfunction

  task automatic frame(input int d, input int n,
                       input int drop, input bit keep,
                       input logic [7:0] nxt);
    int i, nib, guard, cnt_m;
    bit prev_en, seen, hs;
    logic [7:0] acc;
    logic [31:0] crc_m, f;
    en_len = 0; done_cnt = 0; urun_cnt = 0;
    hs_cnt = 0; fall_cyc = -1; rise_cyc = -1;
    done_cyc = -1; urun_cyc = -1; idle_cyc = -1;
    last4 = '0; acc = '0;
    i = 0; nib = 0; guard = 0; cnt_m = 0;
    prev_en = 0; seen = 0; crc_m = '1;
    for (int k = 0; k < 7; k++) exq.push_back(8'h55);
    exq.push_back(8'hD5);
    s_data[d]  = pay[0];
    s_last[d]  = (n == 1);
    s_valid[d] = 1'b1;
    while (1) begin
      @(negedge clk50);
      cyc++;
      guard++;
      if (tx_en[d]) begin
        if (!prev_en) rise_cyc = cyc;
        en_len++;
        acc = {txd[d], acc[7:2]};
        nib++;
        if (nib == 4) begin
          nib = 0;
          last4 = {acc, last4[31:8]};
          if (exq.size() == 0)
            chk("q_underflow", exq.size(), 1);
          else
            chk("wire_byte", acc, exq.pop_front());
        end
      end
      if (prev_en && !tx_en[d]) fall_cyc = cyc;
      if (tx_busy[d]) seen = 1;
      if (tx_done[d]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_underrun[d]) begin
        urun_cnt++;
        urun_cyc = cyc;
        chk("urun_en_low", tx_en[d], 0);
      end
      hs = rdy[d] && s_valid[d];
      prev_en = tx_en[d];
      if (seen && !tx_busy[d]) begin
        idle_cyc = cyc;
        break;
      end
      if (guard > 5000) begin
        chk("timeout", guard, 0);
        break;
      end
      @(posedge clk50);
      #1;
      if (hs) begin
        hs_cnt++;
        exq.push_back(s_data[d]);
        crc_m = crc_upd(crc_m, s_data[d]);
        cnt_m++;
        if (s_last[d]) begin
          while (cnt_m < minp(d)) begin
            exq.push_back(8'h00);
            crc_m = crc_upd(crc_m, 8'h00);
            cnt_m++;
          end
          if (fcsp(d)) begin
            f = ~crc_m;
            for (int k = 0; k < 4; k++)
              exq.push_back(8'(f >> (8 * k)));
          end
          s_valid[d] = keep;
          s_data[d]  = nxt;
          s_last[d]  = 1'b0;
        end else begin
          i++;
          s_data[d] = pay[i];
          s_last[d] = (i == n - 1);
          if (i == drop) s_valid[d] = 1'b0;
        end
      end
    end
    chk("q_empty", exq.size(), 0);
    exq.delete();
  endtask

  int f1, g, quiet_sum;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      s_data[d]  = '0;
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
    end
    repeat (3) @(negedge clk50);
    for (int d = 0; d < 3; d++)
      chk("reset_outs",
          {tx_en[d], txd[d], rdy[d], tx_busy[d],
           tx_done[d], tx_underrun[d]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk50);

    // single byte, padded to 60, with FCS
    pay[0] = 8'hA5;
    frame(0, 1, -1, 0, 8'h00);
    chk("t1_en_len", en_len, 288);
    chk("t1_hs", hs_cnt, 1);
    chk("t1_done", done_cnt, 1);
    chk("t1_urun", urun_cnt, 0);
    chk("t1_done_pos", done_cyc - fall_cyc + 1, 48);
    chk("t1_busy_fall", idle_cyc - fall_cyc, 48);

    // check value of CRC-32 on the wire, no padding
    for (int k = 0; k < 9; k++) pay[k] = 8'(8'h31 + k);
    frame(1, 9, -1, 0, 8'h00);
    chk("t2_en_len", en_len, 84);
    chk("t2_fcs", last4, 32'hCBF43926);
    chk("t2_done", done_cnt, 1);

    // 64 bytes, no FCS
    for (int k = 0; k < 64; k++) pay[k] = 8'(k * 7 + 3);
    frame(2, 64, -1, 0, 8'h00);
    chk("t3_en_len", en_len, 288);
    chk("t3_hs", hs_cnt, 64);
    chk("t3_done", done_cnt, 1);

    // underrun on the fifth ready cycle
    for (int k = 0; k < 10; k++) pay[k] = 8'(8'hC0 + k);
    frame(0, 10, 4, 0, 8'h00);
    chk("t4_urun", urun_cnt, 1);
    chk("t4_done", done_cnt, 0);
    chk("t4_en_len", en_len, 48);
    chk("t4_hs", hs_cnt, 4);
    chk("t4_busy_fall", idle_cyc - urun_cyc, 48);

    // back-to-back frames
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    frame(0, 3, -1, 1, 8'h44);
    f1 = fall_cyc;
    chk("t5a_done", done_cnt, 1);
    chk("t5a_en_len", en_len, 288);
    pay[0] = 8'h44; pay[1] = 8'h55;
    frame(0, 2, -1, 0, 8'h00);
    chk("t5_gap", rise_cyc - f1, 49);
    chk("t5b_en_len", en_len, 288);
    chk("t5b_done", done_cnt, 1);

    // asynchronous reset in the middle of DATA
    s_data[0]  = 8'h11;
    s_last[0]  = 1'b0;
    s_valid[0] = 1'b1;
    repeat (60) @(negedge clk50);
    g = 0;
    while (!rdy[0] && g < 100) begin
      @(negedge clk50);
      g++;
    end
    chk("t6_rdy_seen", rdy[0], 1);
    chk("t6_en_before", tx_en[0], 1);
    #3 rst_n = 1'b0;
    #1 chk("t6_async_drop",
           {tx_en[0], txd[0], rdy[0], tx_busy[0]}, 0);
    s_valid[0] = 1'b0;
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    quiet_sum = 0;
    repeat (20) begin
      @(negedge clk50);
      quiet_sum += int'(tx_done[0]) +
                   int'(tx_underrun[0]) +
                   int'(tx_busy[0]) + int'(tx_en[0]);
    end
    chk("t6_quiet", quiet_sum, 0);
    for (int k = 0; k < 5; k++) pay[k] = 8'(8'h90 + k);
    frame(0, 5, -1, 0, 8'h00);
    chk("t6_en_len", en_len, 288);
    chk("t6_done", done_cnt, 1);
    chk("t6_urun", urun_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rmii_tx.md
Name: rmii_tx

Overview:
- RMII transmit MAC framer. Takes a byte stream from the upper layer (packet builder) and drives the PHY TX dibit interface.
- Per frame it emits preamble, SFD, payload, zero padding up to a minimum length, the Ethernet FCS (CRC-32), then holds the inter-frame gap.
- It is the transmit counterpart of the RMII receive path, and shares the 50 MHz RMII reference clock with it.

Parameters:
- PREAMBLE_BYTES, 7, number of 0x55 bytes sent before the SFD (0xD5).
- MIN_PAYLOAD, 60, minimum bytes before FCS; shorter payloads are zero-padded; 0 disables padding.
- APPEND_FCS, 1, 1 = append 4-byte CRC-32 FCS; 0 = no FCS.
- IFG_BYTES, 12, inter-frame gap in byte times (4 clocks each), tx_en low.

Ports:
- clk50 input 1: 50 MHz RMII reference clock; the only clock.
- rst_n input 1: reset, asynchronous, active-low.
- s_data input 8: payload byte.
- s_valid input 1: s_data valid; asserting in IDLE starts a frame.
- s_last input 1: qualifies s_data as the final payload byte.
- s_ready output 1: byte accepted on a cycle with s_valid && s_ready.
- txd output 2: RMII transmit dibit.
- tx_en output 1: RMII transmit enable.
- tx_busy output 1: high from frame start through the end of the IFG.
- tx_done output 1: one-cycle pulse on the last IFG cycle of a normally completed frame.
- tx_underrun output 1: one-cycle pulse when a frame is aborted for lack of data.

Behaviour:
- Reset (async, rst_n low): all outputs 0, state IDLE, counters 0. Asserting reset mid-frame drops tx_en and txd to 0 immediately. No done or underrun pulse is produced.
- All outputs are registered.
- Byte serialisation: 4 clocks per byte, LSB dibit first: txd = b[1:0], b[3:2], b[5:4], b[7:6]. A 2-bit sym_cnt tracks position; a new byte loads when sym_cnt wraps 3->0.
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE: tx_en=0, txd=0, s_ready=0. When s_valid=1 at edge k, go to PRE; tx_en=1 and txd=2'b01 from edge k+1. s_data is not consumed yet.
- PRE: PREAMBLE_BYTES x 0x55, then SFD (0xD5, one byte), then DATA.
- s_ready: high only when sym_cnt==3 in SFD, or in DATA before s_last has been accepted. The accepted byte is transmitted starting on the next clock.
- DATA: each accepted byte is fed to the CRC and counted in byte_cnt (11 bits, saturating at 2047). On acceptance with s_last=1:
  - byte_cnt < MIN_PAYLOAD: go to PAD.
  - otherwise, APPEND_FCS=1: go to FCS.
  - otherwise: go to IFG.
- Underrun: if s_valid=0 on an s_ready cycle:
  - abort; tx_en=0 from the next clock;
  - tx_underrun pulses once;
  - go to IFG; no FCS is sent and tx_done is not pulsed.
- PAD: send 0x00 bytes (CRC included) until byte_cnt == MIN_PAYLOAD, then FCS or IFG as above.
- CRC-32 (DATA and PAD bytes only):
  - reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB-first update;
  - FCS = ~crc, sent low byte first (bits [7:0] first).
  - Preamble and SFD are excluded from the CRC.
- FCS: 4 bytes, then IFG. tx_en drops on the clock after the last FCS dibit.
- IFG: tx_en=0, txd=0 for IFG_BYTES*4 clocks. tx_done pulses on the final IFG cycle (normal frames only), then IDLE.
- A new frame may start on the first IDLE cycle (back-to-back frames). s_valid held through IFG is ignored until IDLE.
- tx_busy = (state != IDLE).
- s_last with zero-length payload is impossible, since the first byte always arrives in SFD. s_last asserted during PAD or FCS is not sampled (s_ready=0).

Test Plan:
- 1-byte frame 0xA5, s_last=1, defaults:
  - tx_en high for (8+60+4)*4 = 288 consecutive clocks;
  - dibits 01 x28, then 01,01,01,11 (SFD), then 01,01,10,10 (0xA5), then zeros for 59 bytes, then FCS;
  - FCS matches a software CRC-32 of A5 followed by 59 x 00;
  - tx_done pulses 48 clocks after tx_en falls.
- MIN_PAYLOAD=0, payload ASCII "123456789": FCS bytes on the wire are 0x26, 0x39, 0xF4, 0xCB; tx_en high for (8+9+4)*4 = 84 clocks.
- 64-byte payload, APPEND_FCS=0: no padding, no FCS; tx_en high for 72*4 = 288 clocks; exactly 64 s_valid&&s_ready handshakes.
- Underrun: s_valid dropped on the 5th s_ready cycle:
  - tx_underrun pulses once, tx_en=0 on the next clock;
  - 48 idle clocks follow; tx_done never pulses; tx_busy falls after the IFG.
- Back-to-back: second frame's s_valid held high through the first frame's IFG. Gap between tx_en falling and tx_en rising is exactly 48 + 1 clocks; both FCS values are correct.
- Reset mid-DATA (rst_n low asynchronously):
  - tx_en, txd, s_ready drop without waiting for a clock edge;
  - after release, IDLE with no pulses;
  - a new frame transmits correctly.
